data_bus_bridge: RTL and testbench

Sits between the Harvard CPU's data port and the shared data bus. Converts the CPU's single-cycle data request (address, read/write strobes, byte enables, write data) into a registered, waitrequest-handshaked bus transaction. Drives the CPU's `clk_enable` low until the transaction completes, so a load or store commits only once its data is final. Instruction-side traffic is not handled here.

---
 rtl/data_bus_bridge_if.sv | 30 +++
 rtl/data_bus_bridge.sv | 49 ++++
 tb/tb_data_bus_bridge.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/data_bus_bridge_if.sv
// data_bus_bridge_if: CPU data-port and shared data-bus signals seen by the bridge.
interface data_bus_bridge_if;
  logic        cpu_active;
  logic [31:0] cpu_data_address;
  logic        cpu_data_read;
  logic        cpu_data_write;
  logic [3:0]  cpu_byte_enable;
  logic [31:0] cpu_data_writedata;
  logic [31:0] cpu_data_readdata;
  logic        cpu_clk_enable;
  logic [31:0] bus_address;
  logic        bus_read;
  logic        bus_write;
  logic [3:0]  bus_byteenable;
  logic [31:0] bus_writedata;
  logic        bus_waitrequest;
  logic [31:0] bus_readdata;
  modport master (
    input  cpu_active, cpu_data_address, cpu_data_read, cpu_data_write, cpu_byte_enable,
           cpu_data_writedata, bus_waitrequest, bus_readdata,
    output cpu_data_readdata, cpu_clk_enable, bus_address, bus_read, bus_write,
           bus_byteenable, bus_writedata
  );
  modport slave (
    output cpu_active, cpu_data_address, cpu_data_read, cpu_data_write, cpu_byte_enable,
           cpu_data_writedata, bus_waitrequest, bus_readdata,
    input  cpu_data_readdata, cpu_clk_enable, bus_address, bus_read, bus_write,
           bus_byteenable, bus_writedata
  );
endinterface

// File: rtl/data_bus_bridge.sv
// data_bus_bridge: turns single-cycle CPU data requests into registered, waitrequest-handshaked
// bus transactions, stalling the CPU until the load/store data is final.
module data_bus_bridge (
  input logic               clk,
  input logic               reset,
  data_bus_bridge_if.master dbus
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t      state_q;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [3:0]  be_q;
  logic        rd_q, wr_q, req;
  assign req = dbus.cpu_active & (dbus.cpu_data_read | dbus.cpu_data_write);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      be_q    <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
    end else
      case (state_q)
        IDLE: if (req) begin
          addr_q  <= dbus.cpu_data_address & ~32'h3;
          be_q    <= dbus.cpu_byte_enable;
          wdata_q <= dbus.cpu_data_writedata;
          wr_q    <= dbus.cpu_data_write;
          rd_q    <= !dbus.cpu_data_write;
          state_q <= ACCESS;
        end
        ACCESS: if (!dbus.bus_waitrequest) begin
          if (rd_q) rdata_q <= dbus.bus_readdata;
          rd_q    <= 1'b0;
          wr_q    <= 1'b0;
          state_q <= DONE;
        end
        // the request still visible in DONE belongs to the instruction now committing
        default: state_q <= IDLE;
      endcase
  always_comb dbus.cpu_clk_enable = (state_q == IDLE) ? !req : (state_q == DONE);
  assign dbus.cpu_data_readdata = rdata_q;
  assign dbus.bus_address       = addr_q;
  assign dbus.bus_read          = rd_q;
  assign dbus.bus_write         = wr_q;
  assign dbus.bus_byteenable    = be_q;
  assign dbus.bus_writedata     = wdata_q;
endmodule

// File: tb/tb_data_bus_bridge.sv
// tb_data_bus_bridge: scenario tasks drive CPU requests and a bus slave; a negedge monitor
// pops expected bus transactions from a scoreboard queue as the bus accepts them.
module tb_data_bus_bridge;
  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
  } txn_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  data_bus_bridge_if bif();
  data_bus_bridge dut (.clk(clk), .reset(reset), .dbus(bif.master));
  always #5 clk = ~clk;
  int checks = 0;
  int errors = 0;
  int stb_cycles = 0;
  int rd_cycles = 0;
  int cyc = 0;
  txn_t exp_q[$];
  logic [31:0] exp_rd = '0;
  logic prev_stb = 1'b0;
  logic prev_wait = 1'b0;
  logic [69:0] prev_bundle = '0;
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    logic stb;
    txn_t e;
    if (reset) prev_stb = 1'b0;
    else begin
      stb = bif.bus_read | bif.bus_write;
      if (stb) stb_cycles++;
      if (bif.bus_read) rd_cycles++;
      if (stb && prev_stb && prev_wait) begin
        checks++;
        if ({bif.bus_read, bif.bus_write, bif.bus_address, bif.bus_byteenable, bif.bus_writedata} !== prev_bundle) begin
          errors++;
          $display("FAIL hold_stable: got %h required %h", {bif.bus_read, bif.bus_write, bif.bus_address,
                   bif.bus_byteenable, bif.bus_writedata}, prev_bundle);
        end
      end
      if (stb && !bif.bus_waitrequest) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL bus_txn: unexpected transaction at addr %h", bif.bus_address);
        end else begin
          e = exp_q.pop_front();
          if (bif.bus_write !== e.wr || bif.bus_read !== !e.wr || bif.bus_address !== e.addr ||
              bif.bus_byteenable !== e.be || (e.wr && bif.bus_writedata !== e.wd)) begin
            errors++;
            $display("FAIL bus_txn: got wr=%b rd=%b a=%h be=%h d=%h required wr=%b a=%h be=%h d=%h",
                     bif.bus_write, bif.bus_read, bif.bus_address, bif.bus_byteenable, bif.bus_writedata,
                     e.wr, e.addr, e.be, e.wd);
          end
        end
      end
      prev_stb = stb;
      prev_wait = bif.bus_waitrequest;
      prev_bundle = {bif.bus_read, bif.bus_write, bif.bus_address, bif.bus_byteenable, bif.bus_writedata};
    end
  end
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
  task automatic idle_cpu();
    bif.cpu_data_read = 1'b0;
    bif.cpu_data_write = 1'b0;
  endtask
  // Called at posedge+1; returns at posedge+1 of the IDLE cycle after DONE.
  task automatic do_mem(input logic rd, input logic wr, input logic [31:0] a, input logic [3:0] be,
                        input logic [31:0] wd, input logic [31:0] rdv, input int w, input bit release_req);
    txn_t e;
    int s0 = stb_cycles;
    bif.cpu_active = 1'b1;
    bif.cpu_data_read = rd;
    bif.cpu_data_write = wr;
    bif.cpu_data_address = a;
    bif.cpu_byte_enable = be;
    bif.cpu_data_writedata = wd;
    bif.bus_waitrequest = (w > 0);
    bif.bus_readdata = $urandom;
    e.wr = wr;
    e.addr = {a[31:2], 2'b00};
    e.be = be;
    e.wd = wd;
    exp_q.push_back(e);
    @(negedge clk);
    checks++;
    if (bif.cpu_clk_enable !== 1'b0) begin errors++; $display("FAIL ce_request: got %b required 0", bif.cpu_clk_enable); end
    for (int k = 0; k <= w; k++) begin
      @(posedge clk); #1;
      bif.bus_waitrequest = (k < w);
      bif.bus_readdata = (k < w) ? $urandom : rdv;
      @(negedge clk);
      checks++;
      if (bif.cpu_clk_enable !== 1'b0 || bif.bus_write !== wr || bif.bus_read !== !wr) begin
        errors++;
        $display("FAIL access_cycle%0d: got ce=%b wr=%b rd=%b required ce=0 wr=%b rd=%b", k,
                 bif.cpu_clk_enable, bif.bus_write, bif.bus_read, wr, !wr);
      end
    end
    @(posedge clk); #1;
    bif.bus_waitrequest = 1'b1;
    bif.bus_readdata = $urandom;
    if (!wr) exp_rd = rdv;
    @(negedge clk);
    checks++;
    if (bif.cpu_clk_enable !== 1'b1 || bif.bus_read !== 1'b0 || bif.bus_write !== 1'b0) begin
      errors++;
      $display("FAIL done_cycle: got ce=%b rd=%b wr=%b required ce=1 rd=0 wr=0", bif.cpu_clk_enable, bif.bus_read, bif.bus_write);
    end
    checks++;
    if (bif.cpu_data_readdata !== exp_rd) begin
      errors++;
      $display("FAIL readdata: got %h required %h", bif.cpu_data_readdata, exp_rd);
    end
    checks++;
    if (stb_cycles - s0 !== w + 1) begin
      errors++;
      $display("FAIL strobe_len: got %0d required %0d", stb_cycles - s0, w + 1);
    end
    @(posedge clk); #1;
    if (release_req) idle_cpu();
  endtask
  task automatic test_reset();
    bif.cpu_active = 1'b1;
    idle_cpu();
    bif.cpu_data_address = 32'hFFFF_FFFF;
    bif.cpu_byte_enable = 4'hF;
    bif.cpu_data_writedata = 32'hFFFF_FFFF;
    bif.bus_waitrequest = 1'b0;
    bif.bus_readdata = '0;
    #2;
    checks++;
    if ({bif.bus_read, bif.bus_write, bif.bus_address, bif.bus_byteenable, bif.bus_writedata,
         bif.cpu_data_readdata, bif.cpu_clk_enable} !== {2'b00, 32'h0, 4'h0, 32'h0, 32'h0, 1'b1}) begin
      errors++;
      $display("FAIL reset_state: got rd=%b wr=%b a=%h be=%h wd=%h rdd=%h ce=%b", bif.bus_read, bif.bus_write,
               bif.bus_address, bif.bus_byteenable, bif.bus_writedata, bif.cpu_data_readdata, bif.cpu_clk_enable);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
  endtask
  task automatic test_zero_wait_load();
    do_mem(1'b1, 1'b0, 32'h0000_1006, 4'hF, 32'h0, 32'hDEAD_BEEF, 0, 1'b1);
  endtask
  task automatic test_waited_store();
    do_mem(1'b0, 1'b1, 32'h0000_0020, 4'b0011, 32'h1234_5678, 32'h0, 3, 1'b1);
  endtask
  task automatic test_both_strobes();
    int r0 = rd_cycles;
    do_mem(1'b1, 1'b1, 32'h0000_0443, 4'b1100, 32'hCAFE_F00D, 32'h0, 1, 1'b1);
    checks++;
    if (rd_cycles !== r0) begin errors++; $display("FAIL both_no_read: got %0d read cycles required 0", rd_cycles - r0); end
  endtask
  task automatic test_zero_be();
    do_mem(1'b0, 1'b1, 32'h8000_0011, 4'b0000, 32'hA5A5_5A5A, 32'h0, 0, 1'b1);
    do_mem(1'b1, 1'b0, 32'h8000_0013, 4'b0000, 32'h0, 32'h0BAD_F00D, 2, 1'b1);
  endtask
  task automatic test_noop_stream();
    int s0 = stb_cycles;
    bif.cpu_active = 1'b1;
    idle_cpu();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (bif.cpu_clk_enable !== 1'b1) begin errors++; $display("FAIL noop_ce%0d: got %b required 1", i, bif.cpu_clk_enable); end
      @(posedge clk); #1;
    end
    checks++;
    if (stb_cycles !== s0) begin errors++; $display("FAIL noop_strobes: got %0d required 0", stb_cycles - s0); end
  endtask
  task automatic test_inactive();
    int s0 = stb_cycles;
    bif.cpu_active = 1'b0;
    bif.cpu_data_read = 1'b1;
    bif.cpu_data_write = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (bif.cpu_clk_enable !== 1'b1) begin errors++; $display("FAIL inactive_ce%0d: got %b required 1", i, bif.cpu_clk_enable); end
      @(posedge clk); #1;
    end
    checks++;
    if (stb_cycles !== s0) begin errors++; $display("FAIL inactive_strobes: got %0d required 0", stb_cycles - s0); end
    idle_cpu();
    bif.cpu_active = 1'b1;
  endtask
  task automatic test_back_to_back();
    int c0 = cyc;
    int s0 = stb_cycles;
    do_mem(1'b1, 1'b0, 32'h0000_0100, 4'hF, 32'h0, 32'h7654_3210, 0, 1'b0);
    do_mem(1'b0, 1'b1, 32'h0000_0104, 4'hF, 32'h1111_2222, 32'h0, 0, 1'b1);
    checks++;
    if (cyc - c0 !== 6) begin errors++; $display("FAIL b2b_cycles: got %0d required 6", cyc - c0); end
    @(negedge clk);
    checks++;
    if (stb_cycles - s0 !== 2 || bif.bus_read !== 1'b0 || bif.bus_write !== 1'b0) begin
      errors++;
      $display("FAIL b2b_txns: got %0d strobe cycles rd=%b wr=%b required 2 rd=0 wr=0", stb_cycles - s0, bif.bus_read, bif.bus_write);
    end
    @(posedge clk); #1;
  endtask
  task automatic test_reset_mid_access();
    int s0;
    bif.cpu_active = 1'b1;
    bif.cpu_data_read = 1'b1;
    bif.cpu_data_address = 32'h0000_0200;
    bif.cpu_byte_enable = 4'hF;
    bif.bus_waitrequest = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bif.bus_read !== 1'b1) begin errors++; $display("FAIL rst_pre_read: got %b required 1", bif.bus_read); end
    reset = 1'b1;
    #1;
    checks++;
    if ({bif.bus_read, bif.bus_write, bif.bus_address, bif.cpu_data_readdata, bif.cpu_clk_enable} !== {2'b00, 32'h0, 32'h0, 1'b0}) begin
      errors++;
      $display("FAIL rst_mid_access: got rd=%b wr=%b a=%h rdd=%h ce=%b required rd=0 wr=0 a=0 rdd=0 ce=0",
               bif.bus_read, bif.bus_write, bif.bus_address, bif.cpu_data_readdata, bif.cpu_clk_enable);
    end
    idle_cpu();
    bif.bus_waitrequest = 1'b0;
    exp_rd = '0;
    @(posedge clk); #1;
    reset = 1'b0;
    s0 = stb_cycles;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (bif.cpu_clk_enable !== 1'b1 || bif.cpu_data_readdata !== 32'h0) begin
        errors++;
        $display("FAIL rst_after%0d: got ce=%b rdd=%h required ce=1 rdd=0", i, bif.cpu_clk_enable, bif.cpu_data_readdata);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (stb_cycles !== s0) begin errors++; $display("FAIL rst_no_txn: got %0d strobe cycles required 0", stb_cycles - s0); end
  endtask
  initial begin
    test_reset();
    test_zero_wait_load();
    test_waited_store();
    test_both_strobes();
    test_zero_be();
    test_noop_stream();
    test_inactive();
    test_back_to_back();
    test_reset_mid_access();
    checks++;
    if (exp_q.size() !== 0) begin errors++; $display("FAIL scoreboard_drain: got %0d pending required 0", exp_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
